pwm_bidir_multi: RTL

Multi-channel successor to the single-channel bidirectional PWM generator for H-bridge motor drivers.
- Converts one signed command per channel into dir1/dir2/pwm_out.
- Commands are double-buffered, so duty and direction change only at period boundaries.
- Each channel has its own direction FSM with dead-time, a saturation flag and a global enable.
- Sits between the per-motor PID controllers and the gate-driver pins.

---
 rtl/pwm_bidir_multi.sv | 311 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_bidir_multi.sv
// pwm_bidir_multi
// Multi-channel bidirectional PWM generator for H-bridge gate drivers.
// Each channel turns a signed command into dir1/dir2/pwm_out. Commands land
// in a shadow register and are promoted to the active register on a period
// boundary. Every direction change passes through a dead-time state.
// Optional build macro: CENTER_ALIGNED_EN selects an up/down (centre-aligned)
// period counter; when it is undefined the counter is an edge-aligned sawtooth.
module pwm_bidir_multi #(
  parameter int NUM_CH          = 2,
  parameter int CMD_W           = 16,
  parameter int CNT_W           = 16,
  parameter int MAX_COUNT       = 4000,
  parameter int DEADTIME_CYCLES = 3,
  parameter int DT_W            = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [NUM_CH*CMD_W-1:0] cmd,
  input  logic [NUM_CH-1:0]       cmd_valid,
  output logic [NUM_CH-1:0]       dir1,
  output logic [NUM_CH-1:0]       dir2,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic [NUM_CH-1:0]       sat_flag,
  output logic                    period_start
);

  // Width wide enough to compare the (CMD_W+1)-bit magnitude with MAX_COUNT.
  localparam int AW = ((CMD_W + 1) > CNT_W) ? (CMD_W + 1) : CNT_W;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_COUNT - 1);
  localparam logic [CNT_W-1:0] MAG_MAX  = CNT_W'(MAX_COUNT);
  localparam logic [AW-1:0]    MAG_MAX_W = AW'(MAX_COUNT);
  localparam logic [DT_W-1:0]  DT_LOAD  = DT_W'(DEADTIME_CYCLES);
  localparam logic [DT_W-1:0]  DT_ONE   = DT_W'(1);

  typedef enum logic [1:0] {
    DIR_STOP = 2'd0,
    DIR_CW   = 2'd1,
    DIR_CCW  = 2'd2
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CW   = 2'd1,
    ST_CCW  = 2'd2,
    ST_DEAD = 2'd3
  } state_t;

  // Run state that corresponds to a commanded direction.
  function automatic state_t dir_to_state(input dir_t d);
    state_t s;
    case (d)
      DIR_CW:  s = ST_CW;
      DIR_CCW: s = ST_CCW;
      default: s = ST_IDLE;
    endcase
    return s;
  endfunction

  // ------------------------------------------------------------------
  // Shared period counter
  // ------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             boundary;   // edge on which shadow is promoted to active
  logic             ps_pulse;   // counter position that raises period_start

`ifdef CENTER_ALIGNED_EN
  logic up_reg;
  logic up_next;

  // Triangle count: up to MAX_COUNT-1, down to 0, held at 0 while disabled.
  always_comb begin
    cnt_next = cnt_reg;
    up_next  = up_reg;
    if (!enable) begin
      cnt_next = CNT_ZERO;
      up_next  = 1'b1;
    end else if (up_reg) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_next = cnt_reg - CNT_ONE;
        up_next  = 1'b0;
      end else begin
        cnt_next = cnt_reg + CNT_ONE;
      end
    end else begin
      if (cnt_reg == CNT_ZERO) begin
        cnt_next = CNT_ONE;
        up_next  = 1'b1;
      end else begin
        cnt_next = cnt_reg - CNT_ONE;
      end
    end
  end

  // Direction register of the triangle counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_reg <= 1'b1;
    end else begin
      up_reg <= up_next;
    end
  end

  // Both the update and the period marker sit at the valley of the triangle.
  assign boundary = enable && !up_reg && (cnt_reg == CNT_ZERO);
  assign ps_pulse = boundary;
`else
  // Sawtooth count 0..MAX_COUNT-1, held at 0 while disabled.
  always_comb begin
    cnt_next = cnt_reg;
    if (!enable) begin
      cnt_next = CNT_ZERO;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_next = CNT_ZERO;
    end else begin
      cnt_next = cnt_reg + CNT_ONE;
    end
  end

  assign boundary = enable && (cnt_reg == CNT_LAST);
  assign ps_pulse = enable && (cnt_reg == CNT_ZERO);
`endif

  // Period counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= CNT_ZERO;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // period_start is a registered copy of the counter-position pulse.
  logic period_start_reg;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_start_reg <= 1'b0;
    end else begin
      period_start_reg <= ps_pulse;
    end
  end
  assign period_start = period_start_reg;

  // ------------------------------------------------------------------
  // Per-channel datapath and direction FSM
  // ------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CMD_W-1:0] cmd_ch;
    logic [CMD_W:0]   cmd_ext;
    logic [CMD_W:0]   cmd_abs;
    logic [AW-1:0]    abs_w;
    logic             clip;
    logic [CNT_W-1:0] mag_in;
    dir_t             dir_in;

    // Magnitude is formed one bit wider than the command so that the most
    // negative command converts exactly before it is clipped.
    assign cmd_ch  = cmd[gi*CMD_W +: CMD_W];
    assign cmd_ext = {cmd_ch[CMD_W-1], cmd_ch};
    assign cmd_abs = cmd_ch[CMD_W-1] ? ((CMD_W+1)'(0) - cmd_ext) : cmd_ext;
    assign abs_w   = AW'(cmd_abs);
    assign clip    = (abs_w > MAG_MAX_W);
    assign mag_in  = clip ? MAG_MAX : CNT_W'(abs_w);
    assign dir_in  = (cmd_ch == '0)      ? DIR_STOP :
                     cmd_ch[CMD_W-1]     ? DIR_CCW  : DIR_CW;

    dir_t             sh_dir_reg;
    logic [CNT_W-1:0] sh_mag_reg;
    logic             sh_sat_reg;
    dir_t             act_dir_reg;
    logic [CNT_W-1:0] act_mag_reg;
    logic             act_sat_reg;

    // Shadow register: last write in a period wins; kept across disable.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sh_dir_reg <= DIR_STOP;
        sh_mag_reg <= CNT_ZERO;
        sh_sat_reg <= 1'b0;
      end else if (cmd_valid[gi]) begin
        sh_dir_reg <= dir_in;
        sh_mag_reg <= mag_in;
        sh_sat_reg <= clip;
      end
    end

    // Active register: promoted from shadow only at the boundary edge,
    // cleared whenever the block is disabled.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        act_dir_reg <= DIR_STOP;
        act_mag_reg <= CNT_ZERO;
        act_sat_reg <= 1'b0;
      end else if (!enable) begin
        act_dir_reg <= DIR_STOP;
        act_mag_reg <= CNT_ZERO;
        act_sat_reg <= 1'b0;
      end else if (boundary) begin
        act_dir_reg <= sh_dir_reg;
        act_mag_reg <= sh_mag_reg;
        act_sat_reg <= sh_sat_reg;
      end
    end

    state_t          state_reg;
    state_t          state_next;
    logic [DT_W-1:0] dead_reg;
    logic [DT_W-1:0] dead_next;
    dir_t            tgt_reg;     // direction the dead time is leading into
    dir_t            tgt_next;

    // FSM state, dead-time counter and pending direction.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_reg <= ST_IDLE;
        dead_reg  <= '0;
        tgt_reg   <= DIR_STOP;
      end else begin
        state_reg <= state_next;
        dead_reg  <= dead_next;
        tgt_reg   <= tgt_next;
      end
    end

    // Next-state: any change of commanded direction goes through DEAD; a
    // further change while in DEAD restarts the dead time.
    always_comb begin
      state_next = state_reg;
      dead_next  = dead_reg;
      tgt_next   = tgt_reg;
      if (!enable) begin
        state_next = ST_IDLE;
        dead_next  = '0;
        tgt_next   = DIR_STOP;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (act_dir_reg != DIR_STOP) begin
              state_next = ST_DEAD;
              dead_next  = DT_LOAD;
              tgt_next   = act_dir_reg;
            end
          end
          ST_CW: begin
            if (act_dir_reg != DIR_CW) begin
              state_next = ST_DEAD;
              dead_next  = DT_LOAD;
              tgt_next   = act_dir_reg;
            end
          end
          ST_CCW: begin
            if (act_dir_reg != DIR_CCW) begin
              state_next = ST_DEAD;
              dead_next  = DT_LOAD;
              tgt_next   = act_dir_reg;
            end
          end
          ST_DEAD: begin
            if (act_dir_reg != tgt_reg) begin
              dead_next = DT_LOAD;
              tgt_next  = act_dir_reg;
            end else if (dead_reg <= DT_ONE) begin
              state_next = dir_to_state(act_dir_reg);
              dead_next  = '0;
            end else begin
              dead_next = dead_reg - DT_ONE;
            end
          end
          default: begin
            state_next = ST_IDLE;
            dead_next  = '0;
            tgt_next   = DIR_STOP;
          end
        endcase
      end
    end

    logic dir1_reg;
    logic dir2_reg;
    logic pwm_reg;

    // Registered pin drivers; dir1/dir2 derive from one state so they can
    // never be high together, and DEAD/IDLE force everything low.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        dir1_reg <= 1'b0;
        dir2_reg <= 1'b0;
        pwm_reg  <= 1'b0;
      end else if (!enable) begin
        dir1_reg <= 1'b0;
        dir2_reg <= 1'b0;
        pwm_reg  <= 1'b0;
      end else begin
        dir1_reg <= (state_reg == ST_CW);
        dir2_reg <= (state_reg == ST_CCW);
        pwm_reg  <= ((state_reg == ST_CW) || (state_reg == ST_CCW)) &&
                    (cnt_reg < act_mag_reg);
      end
    end

    assign dir1[gi]     = dir1_reg;
    assign dir2[gi]     = dir2_reg;
    assign pwm_out[gi]  = pwm_reg;
    assign sat_flag[gi] = act_sat_reg;
  end

endmodule
